// File: rtl/mfm_write_encoder.sv
// MFM write encoder: accepts bytes over valid/ready, serializes MSB-first and
// emits fixed-width write pulses on a CELL_CLKS cell grid, with address-mark support.
module mfm_write_encoder #(
  parameter int CELL_CLKS  = 5,
  parameter int PULSE_CLKS = 2
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_mark,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       mfm_out,
  output logic       wr_gate
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [4:0] CNT_LAST  = 5'(CELL_CLKS - 1);
  localparam logic [4:0] PULSE_LEN = 5'(PULSE_CLKS);
  localparam logic [3:0] MARK_CELL = 4'd10;

  state_t     state, state_nxt;
  logic [7:0] hold_data;
  logic       hold_mark;
  logic       hold_full;
  logic [7:0] shift_reg, shift_nxt;
  logic       shift_mark, mark_nxt;
  logic       prev_bit, prev_nxt;
  logic [3:0] cell_idx, idx_nxt;
  logic [4:0] cell_cnt, cnt_nxt;
  logic       accept, cell_end, load, pulse, mfm_nxt;

  assign din_ready = !hold_full;
  assign accept    = din_valid && !hold_full;
  assign cell_end  = (cell_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    mark_nxt  = shift_mark;
    prev_nxt  = prev_bit;
    idx_nxt   = cell_idx;
    cnt_nxt   = cell_cnt;
    load      = 1'b0;
    pulse     = 1'b0;
    mfm_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = SEND;
          shift_nxt = hold_data;
          mark_nxt  = hold_mark;
          prev_nxt  = 1'b0;
          idx_nxt   = 4'd0;
          cnt_nxt   = 5'd0;
        end
      end
      SEND: begin
        if (!cell_end) begin
          cnt_nxt = cell_cnt + 5'd1;
        end else begin
          cnt_nxt = 5'd0;
          idx_nxt = cell_idx + 4'd1;
          // Closing a data cell: the bit just written becomes prev_bit.
          if (cell_idx[0]) begin
            prev_nxt  = shift_reg[7];
            shift_nxt = {shift_reg[6:0], 1'b0};
          end
          if (cell_idx == 4'd15) begin
            if (hold_full) begin
              load      = 1'b1;
              shift_nxt = hold_data;
              mark_nxt  = hold_mark;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The pulse decision is made for the cell being entered so mfm_out can be registered.
    if (idx_nxt[0]) begin
      pulse = shift_nxt[7];
    end else begin
      pulse = !shift_nxt[7] && !prev_nxt && !(mark_nxt && idx_nxt == MARK_CELL);
    end
    mfm_nxt = (state_nxt == SEND) && pulse && (cnt_nxt < PULSE_LEN);
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= 8'd0;
      shift_mark <= 1'b0;
      prev_bit   <= 1'b0;
      cell_idx   <= 4'd0;
      cell_cnt   <= 5'd0;
      mfm_out    <= 1'b0;
      wr_gate    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      shift_mark <= mark_nxt;
      prev_bit   <= prev_nxt;
      cell_idx   <= idx_nxt;
      cell_cnt   <= cnt_nxt;
      mfm_out    <= mfm_nxt;
      wr_gate    <= (state_nxt == SEND);
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      hold_data <= 8'd0;
      hold_mark <= 1'b0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_data <= din;
      hold_mark <= din_mark;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Directed bench for mfm_write_encoder: per-cycle waveforms compared against
// hand-derived 16-cell MFM patterns expanded onto the 5-cycle cell grid.
module tb_mfm_write_encoder;

  localparam int CELL  = 5;
  localparam int PULSE = 2;

  logic       clk_50 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'd0;
  logic       din_mark = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       mfm_out;
  logic       wr_gate;

  int errors = 0;
  int checks = 0;

  mfm_write_encoder #(.CELL_CLKS(CELL), .PULSE_CLKS(PULSE)) dut (
    .clk_50(clk_50),
    .rst(rst),
    .din(din),
    .din_mark(din_mark),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .mfm_out(mfm_out),
    .wr_gate(wr_gate)
  );

  always #10 clk_50 = ~clk_50;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expands a 16-cell pattern (MSB = cell 0) into an 80-cycle waveform.
  function automatic logic [79:0] build_wave(input logic [15:0] pat);
    logic [79:0] w;
    w = '0;
    for (int t = 0; t < 16 * CELL; t++) begin
      w[79 - t] = pat[15 - (t / CELL)] && ((t % CELL) < PULSE);
    end
    return w;
  endfunction

  // Presents a byte and returns just after the accepting edge E0.
  task automatic offer_byte(input logic [7:0] d, input logic m, output logic ok);
    int n;
    @(negedge clk_50);
    din       = d;
    din_mark  = m;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    ok = din_ready;
    @(posedge clk_50);
  endtask

  task automatic test_reset();
    @(negedge clk_50);
    checks++;
    if (mfm_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_mfm: actual=%b required=0", mfm_out); end
    checks++;
    if (wr_gate !== 1'b0) begin errors++; $display("[TB] FAIL reset_gate: actual=%b required=0", wr_gate); end
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: actual=%b required=1", din_ready); end
    rst = 1'b0;
    @(negedge clk_50);
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_release: actual=%b required=1", din_ready); end
  endtask

  task automatic test_single(input logic [7:0] d, input logic m, input logic [15:0] pat, input string name);
    logic        ok;
    logic [79:0] w;
    int          g;
    offer_byte(d, m, ok);
    #1 din_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL %s_accept: actual=%b required=1", name, ok); end
    @(negedge clk_50);
    checks++;
    if (wr_gate !== 1'b0) begin errors++; $display("[TB] FAIL %s_gate_e0: actual=%b required=0", name, wr_gate); end
    @(posedge clk_50);
    w = '0;
    g = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk_50);
      w[79 - t] = mfm_out;
      if (wr_gate) g++;
    end
    @(negedge clk_50);
    checks++;
    if (w !== build_wave(pat)) begin
      errors++;
      $display("[TB] FAIL %s_wave: actual=%h required=%h", name, w, build_wave(pat));
    end
    checks++;
    if (g != 80) begin errors++; $display("[TB] FAIL %s_gate_len: actual=%0d required=80", name, g); end
    checks++;
    if (wr_gate !== 1'b0) begin errors++; $display("[TB] FAIL %s_gate_end: actual=%b required=0", name, wr_gate); end
  endtask

  task automatic test_back_to_back();
    logic         ok;
    logic [159:0] w;
    logic [159:0] exp_w;
    int           g;
    offer_byte(8'h01, 1'b0, ok);
    #1 din = 8'h00;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: actual=%b required=1", ok); end
    @(posedge clk_50);
    w = '0;
    g = 0;
    for (int t = 0; t < 160; t++) begin
      @(negedge clk_50);
      if (t == 1) begin
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_held: actual=%b required=0", din_ready); end
        din_valid = 1'b0;
        din = 8'h55;
      end
      w[159 - t] = mfm_out;
      if (wr_gate) g++;
    end
    @(negedge clk_50);
    exp_w = {build_wave(16'hAAA9), build_wave(16'h2AAA)};
    checks++;
    if (w !== exp_w) begin errors++; $display("[TB] FAIL b2b_wave: actual=%h required=%h", w, exp_w); end
    checks++;
    if (g != 160) begin errors++; $display("[TB] FAIL b2b_gate_len: actual=%0d required=160", g); end
    checks++;
    if (wr_gate !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gate_end: actual=%b required=0", wr_gate); end
  endtask

  task automatic test_late_transfer();
    logic        ok;
    logic [79:0] w;
    int          g;
    offer_byte(8'h00, 1'b0, ok);
    #1 din_valid = 1'b0;
    @(posedge clk_50);
    w = '0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk_50);
      w[79 - t] = mfm_out;
      if (t == 79) begin
        din       = 8'h00;
        din_mark  = 1'b0;
        din_valid = 1'b1;
      end
    end
    @(negedge clk_50);
    din_valid = 1'b0;
    checks++;
    if (w !== build_wave(16'hAAAA)) begin errors++; $display("[TB] FAIL late_first_wave: actual=%h required=%h", w, build_wave(16'hAAAA)); end
    checks++;
    if (wr_gate !== 1'b0) begin errors++; $display("[TB] FAIL late_gate_gap: actual=%b required=0", wr_gate); end
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL late_held: actual=%b required=0", din_ready); end
    @(posedge clk_50);
    w = '0;
    g = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk_50);
      w[79 - t] = mfm_out;
      if (wr_gate) g++;
    end
    @(negedge clk_50);
    checks++;
    if (w !== build_wave(16'hAAAA)) begin errors++; $display("[TB] FAIL late_second_wave: actual=%h required=%h", w, build_wave(16'hAAAA)); end
    checks++;
    if (g != 80) begin errors++; $display("[TB] FAIL late_gate_len: actual=%0d required=80", g); end
  endtask

  task automatic test_async_reset();
    logic ok;
    int   seen;
    offer_byte(8'h00, 1'b0, ok);
    #1 din_valid = 1'b0;
    @(posedge clk_50);
    @(negedge clk_50);
    checks++;
    if (mfm_out !== 1'b1) begin errors++; $display("[TB] FAIL ar_pulse_before: actual=%b required=1", mfm_out); end
    din       = 8'hFF;
    din_valid = 1'b1;
    @(posedge clk_50);
    @(negedge clk_50);
    din_valid = 1'b0;
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL ar_held: actual=%b required=0", din_ready); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (mfm_out !== 1'b0) begin errors++; $display("[TB] FAIL ar_mfm: actual=%b required=0", mfm_out); end
    checks++;
    if (wr_gate !== 1'b0) begin errors++; $display("[TB] FAIL ar_gate: actual=%b required=0", wr_gate); end
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL ar_ready: actual=%b required=1", din_ready); end
    @(negedge clk_50);
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_50);
      if (mfm_out || wr_gate) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL ar_idle_quiet: actual=%0d active cycles required=0", seen); end
  endtask

  initial begin
    $display("[TB] mfm_write_encoder bench start");
    test_reset();
    test_single(8'h00, 1'b0, 16'hAAAA, "byte00");
    test_single(8'hFF, 1'b0, 16'h5555, "byteFF");
    test_single(8'hA1, 1'b1, 16'h4489, "markA1");
    test_single(8'hA1, 1'b0, 16'h44A9, "dataA1");
    test_back_to_back();
    test_late_transfer();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
